bcd_cascade_counter: RTL and testbench
======================================

// Module: bcd_cascade_counter
// PURPOSE
//   Parametrised multi-digit BCD counter for the stopwatch datapath: DIGITS
//   cascaded 4-bit digits, each with its own terminal value, so one instance
//   counts e.g. mm:ss (9,5,9,5) or hundredths.
//   Up/down counting, parallel load with clamping, and a chain carry/borrow
//   output for cascading instances.
//   Driven by the stopwatch tick enable; Count_out feeds the 7-segment decoders.
// PARAMETERS
//   DIGITS  4        number of BCD digits (1..8)
//   LIMITS  16'h5959 packed terminal values, digit i max = LIMITS[4i+3:4i];
//                    each nibble 1..9, width DIGITS*4 (default = 59:59)
// PORTS
//   Clk         in   1         clock, all state on rising edge
//   Reset       in   1         synchronous, active-high reset
//   Enable      in   1         count one step this cycle (tick)
//   Down        in   1         0 = count up, 1 = count down
//   Load        in   1         load Load_value this cycle
//   Load_value  in   4*DIGITS  packed BCD load value, digit 0 = LSBs
//   Count_out   out  4*DIGITS  packed BCD count, digit 0 = LSBs, registered
//   Carry_out   out  1         combinational: chain wraps on this edge
// BEHAVIOUR
// - Priority per rising Clk: Reset > Load > Enable > hold.
// - Reset=1: every Count_out digit <= 0; Carry_out forced 0 while Reset=1.
// - Load=1 (Reset=0): digit i <= min(Load_value digit i, LIMIT i); nibbles
//   >9 also clamp to LIMIT i. Enable/Down ignored that cycle; Carry_out=0.
// - Enable=0, Load=0: all digits hold; Carry_out=0.
// - Up (Enable=1, Down=0): digit 0 steps every cycle; digit i>0 steps only
//   when digits 0..i-1 are all at their LIMIT. Step: LIMIT i -> 0, else +1.
// - Down (Enable=1, Down=1): digit i>0 steps only when digits 0..i-1 all 0.
//   Step: 0 -> LIMIT i, else -1.
// - Latency: one cycle; Count_out reflects a step on the edge that samples
//   Enable=1.
// - Carry_out = Enable & ~Load & ~Reset & (Down ? all digits 0 :
//   all digits at LIMIT). High the cycle before the full-chain wrap; intended as
//   the Enable of the next cascaded instance.
// - Full wrap: up from all-LIMIT -> all 0; down from all 0 -> all-LIMIT.
//   No saturation, no sticky flag.
// - Down may change on any cycle; the new direction applies on that edge.
//   No extra state.
// - Reset asserted mid-count clears on the next edge regardless of Load/Enable.
// - Digit values outside 0..LIMIT are unreachable; Load clamps out-of-range
//   values to LIMIT.
// TESTING
//   1 Reset=1 from arbitrary count for 1 cycle -> Count_out=16'h0000,
//     Carry_out=0.
//   2 Default params, up, Enable=1 from 0, 60 ticks -> 16'h0100 (01:00); at
//     tick 9 count 16'h0009 -> 16'h0010.
//   3 Load 16'h5959, up, Enable=1 -> Carry_out=1 that cycle, next Count_out=0;
//     Enable=0 at 16'h5959 -> Carry_out=0, hold.
//   4 Load 16'h0000, Down=1, Enable=1 -> Carry_out=1, next 16'h5959; next tick
//     16'h5958; from 16'h0100 one tick -> 16'h0059.
//   5 Load 16'h7A93 -> Count_out=16'h5953 (clamped); Load=1 with Enable=1 ->
//     load wins, no step.
//   6 Reset=1 and Load=1 on same edge -> 0; Down toggled every cycle from
//     16'h0010 -> 0009, 0010, 0009.

Source files
------------

// File: rtl/bcd_cascade_counter.sv
// Cascaded multi-digit BCD counter with per-digit terminal values, up/down stepping,
// clamped parallel load and a full-chain carry/borrow for cascading instances.
module bcd_cascade_counter #(
    parameter int unsigned         DIGITS = 4,
    parameter logic [4*DIGITS-1:0] LIMITS = 16'h5959
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Enable,
    input  logic                Down,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] Load_value,
    output logic [4*DIGITS-1:0] Count_out,
    output logic                Carry_out
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic [DIGITS-1:0]   at_max, at_zero;
    logic [DIGITS-1:0]   up_en, dn_en;

    // Per-digit terminal/zero detection.
    always_comb begin
        at_max  = '0;
        at_zero = '0;
        for (int i = 0; i < DIGITS; i++) begin
            at_max[i]  = (count_q[4*i +: 4] == LIMITS[4*i +: 4]);
            at_zero[i] = (count_q[4*i +: 4] == 4'd0);
        end
    end

    // Digit i may step only when every lower digit is about to wrap in the
    // current direction; a running AND avoids a self-referencing vector.
    always_comb begin
        logic run_up;
        logic run_dn;
        up_en  = '0;
        dn_en  = '0;
        run_up = 1'b1;
        run_dn = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            up_en[i] = run_up;
            dn_en[i] = run_dn;
            run_up   = run_up & at_max[i];
            run_dn   = run_dn & at_zero[i];
        end
    end

    always_comb begin
        logic [3:0] digit;
        logic [3:0] lim;
        count_d = count_q;
        digit   = '0;
        lim     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            lim = LIMITS[4*i +: 4];
            if (Load) begin
                // Limits never exceed 9, so this also clamps non-BCD nibbles.
                digit = Load_value[4*i +: 4];
                count_d[4*i +: 4] = (digit > lim) ? lim : digit;
            end else if (Enable) begin
                digit = count_q[4*i +: 4];
                if (Down) begin
                    if (dn_en[i]) begin
                        count_d[4*i +: 4] = at_zero[i] ? lim : digit - 4'd1;
                    end
                end else begin
                    if (up_en[i]) begin
                        count_d[4*i +: 4] = at_max[i] ? 4'd0 : digit + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count_out = count_q;
    assign Carry_out = Enable & ~Load & ~Reset & (Down ? (&at_zero) : (&at_max));

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed self-checking bench for bcd_cascade_counter with default parameters (59:59).
module tb_bcd_cascade_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        down;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count_out;
    logic        carry_out;

    int checks   = 0;
    int failures = 0;

    bcd_cascade_counter dut (
        .Clk        (clk),
        .Reset      (reset),
        .Enable     (enable),
        .Down       (down),
        .Load       (load),
        .Load_value (load_value),
        .Count_out  (count_out),
        .Carry_out  (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] exp);
        checks++;
        assert (count_out === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, count_out, exp);
        end
    endtask

    task automatic check_cy(input string tag, input logic exp);
        #1;
        checks++;
        assert (carry_out === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, carry_out, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load       = 1'b1;
        enable     = 1'b0;
        load_value = v;
        tick();
        load       = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        down       = 1'b0;
        load       = 1'b0;
        load_value = 16'h0000;
        tick();
        reset = 1'b0;

        // Reset from an arbitrary count, with Enable/Down active.
        do_load(16'h1234);
        check_cnt("load_1234", 16'h1234);
        reset  = 1'b1;
        enable = 1'b1;
        down   = 1'b1;
        tick();
        check_cnt("reset_clear", 16'h0000);
        check_cy("carry_in_reset", 1'b0);
        reset = 1'b0;
        check_cy("borrow_at_zero", 1'b1);

        // Up count 60 ticks from zero.
        down = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_cnt("up_9", 16'h0009);
        check_cy("no_carry_mid", 1'b0);
        tick();
        check_cnt("up_10", 16'h0010);
        for (int i = 0; i < 50; i++) tick();
        check_cnt("up_60", 16'h0100);

        // Partial ripple through two digits.
        do_load(16'h0959);
        enable = 1'b1;
        tick();
        check_cnt("ripple_1000", 16'h1000);

        // Full wrap up and hold at all-limit.
        do_load(16'h5959);
        check_cnt("load_5959", 16'h5959);
        check_cy("carry_en0", 1'b0);
        tick();
        check_cnt("hold_5959", 16'h5959);
        load   = 1'b1;
        enable = 1'b1;
        check_cy("carry_load_masks", 1'b0);
        load = 1'b0;
        check_cy("carry_full", 1'b1);
        tick();
        check_cnt("wrap_up", 16'h0000);

        // Full wrap down.
        do_load(16'h0000);
        down   = 1'b1;
        enable = 1'b1;
        check_cy("borrow_full", 1'b1);
        tick();
        check_cnt("wrap_down", 16'h5959);
        tick();
        check_cnt("down_5958", 16'h5958);
        do_load(16'h0100);
        down   = 1'b1;
        enable = 1'b1;
        check_cy("no_borrow_0100", 1'b0);
        tick();
        check_cnt("down_0059", 16'h0059);

        // Clamped load; load beats enable.
        do_load(16'h7A93);
        check_cnt("clamp_7a93", 16'h5953);
        load       = 1'b1;
        enable     = 1'b1;
        down       = 1'b0;
        load_value = 16'h1234;
        tick();
        load = 1'b0;
        enable = 1'b0;
        check_cnt("load_wins", 16'h1234);

        // Reset beats load.
        reset      = 1'b1;
        load       = 1'b1;
        load_value = 16'h4444;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        check_cnt("reset_wins", 16'h0000);

        // Direction toggled every cycle.
        do_load(16'h0010);
        enable = 1'b1;
        down   = 1'b1;
        tick();
        check_cnt("toggle_a", 16'h0009);
        down = 1'b0;
        tick();
        check_cnt("toggle_b", 16'h0010);
        down = 1'b1;
        tick();
        check_cnt("toggle_c", 16'h0009);
        enable = 1'b0;
        tick();
        check_cnt("hold_final", 16'h0009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
